// File: rtl/swcond_pkg.sv
// Shared constants for the switch conditioner: switch indices, switch count and
// default cycle counts for a 50 MHz clock.
package swcond_pkg;

    localparam int unsigned NUM_SW   = 4;

    // Switch roles
    localparam int unsigned SW_SPEED = 0;
    localparam int unsigned SW_SWING = 1;
    localparam int unsigned SW_DIR   = 2;
    localparam int unsigned SW_BLINK = 3;

    // Default cycle counts
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 20 ms
    localparam int unsigned DEF_TICK_CYCLES     = 50_000_000; // 1 s scroll step
    localparam int unsigned DEF_BLINK_CYCLES    = 12_500_000; // 250 ms half-period

endpackage

// File: rtl/debounce_cell.sv
// One switch bit: two-flop synchronizer (inverting the active-low raw input at
// capture) followed by a hold-time debouncer producing an active-high level.
module debounce_cell
    import swcond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw_n,
    output logic o_level
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_sync;
    logic [CntW-1:0] r_cnt;
    logic            r_level;

    // Synchronizer; inversion at the first stage so r_sync[1] is active-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], ~i_raw_n};
        end
    end

    // Level updates only after DEBOUNCE_CYCLES consecutive mismatching cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync[1] == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CntLast) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CntW'(1);
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/switch_conditioner.sv
// Switch front-end: debounced active-high levels, optional edge pulses, scroll
// tick (half period while the speed switch is on) and blink phase.
// Optional feature macro: SW_EDGE_PULSE_EN (builds sw_rise/sw_fall registers;
// when undefined both outputs are tied low).
module switch_conditioner
    import swcond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int unsigned BLINK_CYCLES    = DEF_BLINK_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] dip_switch,
    output logic [NUM_SW-1:0] sw_level,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              scroll_tick,
    output logic              blink_phase
);

    localparam int unsigned TickW  = $clog2(TICK_CYCLES);
    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);
    localparam logic [TickW-1:0]  TickLastSlow = TickW'(TICK_CYCLES - 1);
    localparam logic [TickW-1:0]  TickLastFast = TickW'(TICK_CYCLES / 2 - 1);
    localparam logic [BlinkW-1:0] BlinkLast    = BlinkW'(BLINK_CYCLES - 1);

    logic [NUM_SW-1:0] w_level;
    logic [TickW-1:0]  w_tick_last;
    logic [TickW-1:0]  r_tick_cnt;
    logic              r_tick;
    logic [BlinkW-1:0] r_blink_cnt;
    logic              r_blink;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_cell (
            .clk     (clk),
            .rst     (rst),
            .i_raw_n (dip_switch[g]),
            .o_level (w_level[g])
        );
    end

    assign sw_level = w_level;

`ifdef SW_EDGE_PULSE_EN
    logic [NUM_SW-1:0] r_prev;
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW-1:0] r_fall;

    // Registered compare against previous level gives one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

    assign sw_rise = r_rise;
    assign sw_fall = r_fall;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

    assign w_tick_last = w_level[SW_SPEED] ? TickLastFast : TickLastSlow;

    // Scroll counter; >= lets a speed change past the new limit wrap at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt >= w_tick_last) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + TickW'(1);
            r_tick     <= 1'b0;
        end
    end

    // Blink counter; held in the visible phase while the blink switch is off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!w_level[SW_BLINK]) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BlinkLast) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BlinkW'(1);
        end
    end

    assign scroll_tick = r_tick;
    assign blink_phase = r_blink;

endmodule
